// File: rtl/kb_code_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kb_code_ctrl
// Description : Sequencer between the PS/2 byte receiver and the scan-code to
//               ASCII converter. Tracks E0/F0 prefixes, suppresses typematic
//               repeats, drives key_code and buffers converted characters in
//               a small circular FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module kb_code_ctrl #(
    parameter int W             = 2,
    parameter bit EXT_PASS      = 1'b1,
    parameter bit DROP_UNMAPPED = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic [7:0] key_code,
    input  logic [7:0] ascii_code,
    input  logic       rd_en,
    output logic [7:0] ascii_out,
    output logic       empty,
    output logic       full,
    output logic       drop_tick
);

    localparam int           DEPTH      = 1 << W;
    localparam logic [W:0]   FULL_COUNT = (W+1)'(DEPTH);
    localparam logic [7:0]   BYTE_EXT   = 8'hE0;
    localparam logic [7:0]   BYTE_BRK   = 8'hF0;
    localparam logic [7:0]   UNMAPPED   = 8'h2A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        LOOKUP = 2'd3
    } state_t;

    state_t       state, state_next;
    logic         ext_flag, ext_flag_next;
    logic [8:0]   last_make, last_make_next;
    logic [7:0]   key_code_next;

    logic [7:0]   mem [DEPTH];
    logic [W-1:0] wr_ptr, rd_ptr;
    logic [W:0]   count;

    logic         make_ext;
    logic [8:0]   make_key;
    logic         make_accept;
    logic         is_unmapped;
    logic         do_wr, do_rd;

    // A make byte seen in EXT carries the extend flag; it is accepted unless it
    // repeats the last held key or is an extended key that is not passed on.
    always_comb begin
        make_ext    = (state == EXT);
        make_key    = {make_ext, rx_data};
        make_accept = (make_key != last_make) && (EXT_PASS || !make_ext);
    end

    // Prefix/break parser: next state and registered key tracking.
    always_comb begin
        state_next     = state;
        ext_flag_next  = ext_flag;
        last_make_next = last_make;
        key_code_next  = key_code;
        case (state)
            IDLE, EXT: begin
                if (rx_done_tick) begin
                    if (rx_data == BYTE_EXT) begin
                        state_next = EXT;
                    end else if (rx_data == BYTE_BRK) begin
                        state_next    = BRK;
                        ext_flag_next = make_ext;
                    end else if (make_accept) begin
                        key_code_next  = rx_data;
                        last_make_next = make_key;
                        state_next     = LOOKUP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            BRK: begin
                if (rx_done_tick) begin
                    // Releasing the held key re-arms it for the next press.
                    if ({ext_flag, rx_data} == last_make) begin
                        last_make_next = 9'h000;
                    end
                    state_next = IDLE;
                end
            end
            LOOKUP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Parser registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ext_flag  <= 1'b0;
            last_make <= 9'h000;
            key_code  <= 8'h00;
        end else begin
            state     <= state_next;
            ext_flag  <= ext_flag_next;
            last_make <= last_make_next;
            key_code  <= key_code_next;
        end
    end

    // Write decision in the LOOKUP cycle; a same-cycle pop frees a full slot.
    always_comb begin
        is_unmapped = DROP_UNMAPPED && (ascii_code == UNMAPPED);
        do_rd       = rd_en && !empty;
        do_wr       = (state == LOOKUP) && !is_unmapped && (!full || rd_en);
        drop_tick   = (state == LOOKUP) && !is_unmapped && full && !rd_en;
        empty       = (count == '0);
        full        = (count == FULL_COUNT);
        ascii_out   = mem[rd_ptr];
    end

    // Character FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= ascii_code;
                wr_ptr      <= wr_ptr + W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (W+1)'(1);
                2'b01:   count <= count - (W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kb_code_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kb_code_ctrl
// Description : Self-checking bench for kb_code_ctrl with a behavioural
//               scan-code converter and an expected-character scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kb_code_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd_en;

    logic [7:0] key0, asc0, out0, key1, asc1, out1;
    logic       empty0, full0, drop0, empty1, full1, drop1;

    always #5 clk = ~clk;

    // Converter model: a handful of set-2 scan codes, everything else unmapped.
    function automatic logic [7:0] conv(input logic [7:0] k);
        case (k)
            8'h1C:   conv = 8'h41;
            8'h75:   conv = 8'h38;
            8'h16:   conv = 8'h31;
            8'h1E:   conv = 8'h32;
            8'h26:   conv = 8'h33;
            8'h25:   conv = 8'h34;
            8'h2E:   conv = 8'h35;
            default: conv = 8'h2A;
        endcase
    endfunction

    assign asc0 = conv(key0);
    assign asc1 = conv(key1);

    kb_code_ctrl #(.W(2), .EXT_PASS(1'b1), .DROP_UNMAPPED(1'b1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .key_code(key0), .ascii_code(asc0), .rd_en(rd_en), .ascii_out(out0),
        .empty(empty0), .full(full0), .drop_tick(drop0)
    );

    kb_code_ctrl #(.W(2), .EXT_PASS(1'b0), .DROP_UNMAPPED(1'b0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .key_code(key1), .ascii_code(asc1), .rd_en(rd_en), .ascii_out(out1),
        .empty(empty1), .full(full1), .drop_tick(drop1)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] code;
        logic       push;
        logic [7:0] ch;
        logic       drain;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        rx_done_tick = 1'b0;
        rd_en        = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Pop every expected character from dut0 and compare with the scoreboard.
    task automatic drain(input string name);
        logic [7:0] exp;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            @(negedge clk);
            chk({name, "_nonempty"}, {7'd0, empty0}, 8'd0);
            chk({name, "_head"}, out0, exp);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        @(negedge clk);
        chk({name, "_empty_after"}, {7'd0, empty0}, 8'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        rd_en        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_key_code", key0, 8'h00);
        chk("rst_ascii_out", out0, 8'h00);
        chk("rst_empty", {7'd0, empty0}, 8'd1);
        chk("rst_full", {7'd0, full0}, 8'd0);
        chk("rst_drop", {7'd0, drop0}, 8'd0);
        reset_n = 1'b1;

        // Make/break, typematic, extended keys and unmapped keys on dut0.
        tbl.push_back('{8'h1C, 1'b1, 8'h41, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h1C, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'h1C, 1'b1, 8'h41, 1'b0});
        tbl.push_back('{8'h1C, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h1C, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h1C, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h1C, 1'b1, 8'h41, 1'b1});
        tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h75, 1'b1, 8'h38, 1'b0});
        tbl.push_back('{8'h75, 1'b1, 8'h38, 1'b1});
        tbl.push_back('{8'h05, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h75, 1'b1, 8'h38, 1'b0});
        tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h75, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h75, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h75, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h75, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'h75, 1'b1, 8'h38, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].code);
            if (tbl[i].push) sb.push_back(tbl[i].ch);
            if (tbl[i].drain) drain($sformatf("vec%0d", i));
        end

        // Latency: key_code one edge after the tick, FIFO entry one edge later.
        do_reset();
        @(negedge clk);
        rx_data      = 8'h1C;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        chk("lat_key_code", key0, 8'h1C);
        chk("lat_empty_t1", {7'd0, empty0}, 8'd1);
        @(negedge clk);
        chk("lat_empty_t2", {7'd0, empty0}, 8'd0);
        chk("lat_ascii_t2", out0, 8'h41);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("lat_empty_pop", {7'd0, empty0}, 8'd1);

        // Full FIFO: refused write pulses drop_tick for the LOOKUP cycle only.
        do_reset();
        send(8'h16); sb.push_back(8'h31);
        send(8'h1E); sb.push_back(8'h32);
        send(8'h26); sb.push_back(8'h33);
        send(8'h25); sb.push_back(8'h34);
        chk("full_set", {7'd0, full0}, 8'd1);
        @(negedge clk);
        rx_data      = 8'h2E;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        chk("drop_pulse", {7'd0, drop0}, 8'd1);
        @(negedge clk);
        chk("drop_one_cycle", {7'd0, drop0}, 8'd0);
        chk("full_after_drop", {7'd0, full0}, 8'd1);
        drain("full_drop");

        // Full FIFO with a pop in the LOOKUP cycle: the write is accepted.
        send(8'h16); sb.push_back(8'h31);
        send(8'h1E); sb.push_back(8'h32);
        send(8'h26); sb.push_back(8'h33);
        send(8'h25); sb.push_back(8'h34);
        chk("full_set2", {7'd0, full0}, 8'd1);
        @(negedge clk);
        rx_data      = 8'h2E;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd_en        = 1'b1;
        #1;
        chk("no_drop_with_rd", {7'd0, drop0}, 8'd0);
        chk("head_before_pop", out0, sb.pop_front());
        sb.push_back(8'h35);
        @(negedge clk);
        rd_en = 1'b0;
        chk("full_after_rw", {7'd0, full0}, 8'd1);
        drain("full_rw");

        // Parameter variants: dut1 discards E0 makes and keeps unmapped 2A.
        do_reset();
        send(8'hE0);
        send(8'h75);
        chk("extpass0_empty", {7'd0, empty1}, 8'd1);
        chk("extpass1_head", out0, 8'h38);
        chk("extpass1_nonempty", {7'd0, empty0}, 8'd0);
        send(8'h05);
        chk("unmapped_key0", key0, 8'h05);
        chk("unmapped_key1", key1, 8'h05);
        chk("keep_unmapped_nonempty", {7'd0, empty1}, 8'd0);
        chk("keep_unmapped_head", out1, 8'h2A);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("drop_unmapped_empty", {7'd0, empty0}, 8'd1);
        chk("keep_unmapped_popped", {7'd0, empty1}, 8'd1);

        // Reset in the middle of a break sequence abandons the F0 prefix.
        send(8'h16);
        @(negedge clk);
        rx_data      = 8'hF0;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        reset_n      = 1'b0;
        #1;
        chk("mid_rst_key_code", key0, 8'h00);
        chk("mid_rst_ascii_out", out0, 8'h00);
        chk("mid_rst_empty", {7'd0, empty0}, 8'd1);
        chk("mid_rst_full", {7'd0, full0}, 8'd0);
        chk("mid_rst_drop", {7'd0, drop0}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h1C); sb.push_back(8'h41);
        drain("after_mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kb_code_ctrl.md
# kb_code_ctrl

Sequencing controller between the PS/2 receiver and the scan-code-to-ASCII converter. Parses the raw byte stream and handles the E0 extend and F0 break prefixes. Suppresses typematic repeats and drives the converter's key_code input. Captures each converted ASCII character into a small FIFO, which the configuration and display logic pops one character at a time.

## Interface
- W, 2, FIFO address width; depth = 2^W entries
- EXT_PASS, 1, 1: E0-prefixed make codes are converted; 0: discarded
- DROP_UNMAPPED, 1, 1: converter result 8'h2A (unmapped key) is not written to the FIFO

- clk  in  1  system clock
- reset_n  in  1  reset; one clock; asynchronous, active-low
- rx_done_tick  in  1  one-cycle pulse; rx_data holds a new scan-code byte
- rx_data  in  8  received scan-code byte
- key_code  out  8  registered scan code driven to the converter
- ascii_code  in  8  converter output, combinational from key_code
- rd_en  in  1  pop FIFO head
- ascii_out  out  8  FIFO head character (valid when empty=0)
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- drop_tick  out  1  one-cycle pulse when a character is lost to FIFO full

## Operation
- FSM states:
  - IDLE: waiting for a byte.
  - EXT: E0 seen.
  - BRK: F0 seen; the next byte is a break code.
  - LOOKUP: key_code is registered and awaiting conversion.
- State transitions (only on rx_done_tick unless noted):
  - IDLE, byte E0 -> EXT.
  - IDLE, byte F0 -> BRK, ext_flag=0.
  - IDLE, other byte: make-code handling with ext_flag=0.
  - EXT, byte E0 -> stay in EXT.
  - EXT, byte F0 -> BRK, ext_flag=1.
  - EXT, other byte: make-code handling with ext_flag=1.
  - BRK, any byte: break handling, then -> IDLE.
  - LOOKUP: unconditionally -> IDLE the next cycle.
- Make-code handling:
  - Repeat: if {ext_flag, byte} equals last_make, discard and go to IDLE.
  - EXT_PASS=0 with ext_flag=1: discard and go to IDLE; last_make is not updated.
  - Otherwise: key_code<=byte, last_make<={ext_flag, byte}, -> LOOKUP.
- Break handling:
  - If {ext_flag, byte} equals last_make, last_make<=9'h000.
  - Otherwise no effect; nothing is written to the FIFO.
- LOOKUP: sample ascii_code.
  - If DROP_UNMAPPED=1 and ascii_code=8'h2A: no write.
  - Else if not full, or if rd_en is high the same cycle: write the FIFO.
  - Else (full, no rd_en): drop the character and pulse drop_tick.
- rx_done_tick during LOOKUP is ignored. It cannot occur at PS/2 byte rates.
- FIFO:
  - Circular buffer with W-bit read/write pointers and a count or flag pair.
  - ascii_out = mem[rd_ptr].
  - rd_en while empty is ignored.
  - Simultaneous read and write: both pointers advance, occupancy unchanged.
  - Pointers wrap modulo 2^W.
- Reset (asynchronous, while reset_n=0), including mid-sequence (e.g., in BRK):
  - State, pointers and flags clear.
  - State=IDLE, ext_flag=0, last_make=9'h000, mem cleared to 8'h00.
  - A partially received prefix is abandoned.
- Reset values of outputs: key_code=8'h00, ascii_out=8'h00, empty=1, full=0, drop_tick=0.

## Timing
- Accepted make byte with rx_done_tick at cycle t:
  - key_code updates at the t+1 edge.
  - FIFO write at the t+2 edge.
  - empty falls and ascii_out is valid after t+2, i.e. a 2-cycle latency from rx_done_tick.
- rd_en sampled at cycle r: pointer advances at the r+1 edge; ascii_out shows the next entry after r+1.
- drop_tick is high exactly one cycle: the LOOKUP cycle in which the write was refused.
- Prefix bytes (E0/F0) and break bytes produce no FIFO activity and no key_code change.
- All state changes occur on the rising edge of clk except reset.

## Test plan
- Make then break of A (1C, F0 1C) -> exactly one entry 8'h41; ascii_out=8'h41, empty=0 two cycles after the 1C tick; rd_en -> empty=1.
- Typematic repeat 1C 1C 1C F0 1C 1C -> two entries 8'h41, 8'h41. The second appears only after the break.
- Extended arrow E0 75, EXT_PASS=1 -> entry 8'h38. Follow with unprefixed 75 -> second 8'h38 (different ext_flag, not a repeat). With EXT_PASS=0, E0 75 -> no entry.
- Unmapped key 05 (F1), DROP_UNMAPPED=1 -> no entry, key_code=8'h05. With DROP_UNMAPPED=0 -> entry 8'h2A.
- FIFO full, W=2: makes 16, 1E, 26, 25 with no reads -> full=1. Make 2E -> drop_tick one cycle, FIFO still reads 31 32 33 34. Repeat with rd_en asserted in the LOOKUP cycle -> no drop, FIFO reads 32 33 34 35.
- Reset mid-sequence: F0 received, assert reset_n=0, release, send 1C -> entry 8'h41 (prefix abandoned); all outputs at reset values during reset.
